// File: rtl/dec_addr_sequencer_pkg.sv
// Shared constants and state encoding for the 4:16 decoder select-code sequencer.
package dec_pkg;

    localparam int unsigned SEL_W     = 4;
    localparam int unsigned NUM_LINES = 1 << SEL_W;
    localparam int unsigned GAP_W     = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        PRESENT = 3'd2,
        GAP     = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/dec_addr_sequencer_rr_find.sv
// Round-robin search: lowest set mask bit at or above ptr, wrapping modulo NUM_LINES.
module rr_find
    import dec_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     idx,
    output logic                 found
);

    logic [2*NUM_LINES-1:0] dbl;
    logic [NUM_LINES-1:0]   rot;
    logic [SEL_W-1:0]       off;
    logic                   hit;

    always_comb begin
        // Rotating right by ptr puts line ptr at bit 0, so the lowest hit is the next in turn.
        dbl = {mask, mask} >> ptr;
        rot = dbl[NUM_LINES-1:0];
        off = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            if (rot[i] && !hit) begin
                off = SEL_W'(i);
                hit = 1'b1;
            end
        end
        found = hit;
        idx   = off + ptr;
    end

endmodule

// File: rtl/dec_addr_sequencer.sv
// Sweeps a latched request mask, presenting each line index once in round-robin order
// with a valid/ready handshake and a break-before-make gap between codes.
module dec_addr_sequencer
    import dec_pkg::*;
#(
    parameter int unsigned GAP_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_LINES-1:0] req,
    input  logic                 addr_ready,
    output logic [SEL_W-1:0]     addr,
    output logic                 addr_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    state_t               state, state_nx;
    logic [NUM_LINES-1:0] mask, mask_nx;
    logic [SEL_W-1:0]     ptr, ptr_nx;
    logic [GAP_W-1:0]     gap_cnt, gap_nx;
    logic [SEL_W-1:0]     addr_q, addr_nx;
    logic                 valid_q, busy_q, done_q;
    logic [SEL_W-1:0]     idx;
    logic                 found;

    rr_find u_find (
        .mask  (mask),
        .ptr   (ptr),
        .idx   (idx),
        .found (found)
    );

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        ptr_nx   = ptr;
        gap_nx   = gap_cnt;
        addr_nx  = addr_q;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    mask_nx  = req;
                    state_nx = SEARCH;
                end
            end
            SEARCH: begin
                if (found) begin
                    addr_nx  = idx;
                    state_nx = PRESENT;
                end else begin
                    state_nx = DONE;
                end
            end
            PRESENT: begin
                if (addr_ready) begin
                    mask_nx[addr_q] = 1'b0;
                    ptr_nx          = addr_q + SEL_W'(1);
                    gap_nx          = GAP_LOAD;
                    state_nx        = (GAP_CYC > 0) ? GAP : SEARCH;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nx = SEARCH;
                end else begin
                    gap_nx = gap_cnt - GAP_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort overrides a same-cycle handshake: the presented line stays pending in ptr.
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            mask_nx  = '0;
            ptr_nx   = ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask    <= '0;
            ptr     <= '0;
            gap_cnt <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            mask    <= mask_nx;
            ptr     <= ptr_nx;
            gap_cnt <= gap_nx;
            addr_q  <= addr_nx;
            valid_q <= (state_nx == PRESENT);
            busy_q  <= (state_nx != IDLE);
            done_q  <= (state_nx == DONE);
        end
    end

    assign addr       = addr_q;
    assign addr_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dec_addr_sequencer.sv
// Randomized and directed checks of the select-code sequencer against a queue-based model.
module tb_dec_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] req;
    logic        addr_ready;
    logic [3:0]  addr;
    logic        addr_valid;
    logic        busy;
    logic        done;

    int vec = 0;
    int mis = 0;
    int mptr = 0;

    dec_addr_sequencer #(.GAP_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .req        (req),
        .addr_ready (addr_ready),
        .addr       (addr),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sweep: the model lists the expected service order from the spec's round-robin rule.
    task automatic sweep(input logic [15:0] r, input int ready_pct, input int stall_first,
                         input int abort_hs, input bit restart_mid);
        int          exp_q[$];
        logic [15:0] m;
        int          p;
        int          hs = 0;
        int          vcnt = 0;
        int          c = 1;
        bit          seen_first = 0;
        bit          last_hs = 0;
        bit          stalled = 0;
        bit          ended = 0;
        bit          rdy;
        logic [3:0]  held = '0;

        m = r;
        p = mptr;
        while (m != 16'h0) begin
            for (int i = 0; i < 16; i++) begin
                int j;
                j = (p + i) % 16;
                if (m[j]) begin
                    exp_q.push_back(j);
                    m[j] = 1'b0;
                    p = (j + 1) % 16;
                    break;
                end
            end
        end

        start = 1'b1;
        req   = r;
        tick();
        start = 1'b0;
        req   = 16'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);

        for (int k = 0; k < 1000; k++) begin
            if (last_hs) chk("gap_after_hs", {31'd0, addr_valid}, 32'd0);
            if (stalled) begin
                chk("stall_valid", {31'd0, addr_valid}, 32'd1);
                chk("stall_addr", {28'd0, addr}, {28'd0, held});
            end
            last_hs = 0;
            if (!seen_first && (addr_valid || done)) begin
                seen_first = 1;
                chk("first_latency", c, 2);
            end
            if (done) begin
                chk("done_all_served", exp_q.size(), 0);
                tick();
                chk("done_one_cycle", {31'd0, done}, 32'd0);
                chk("idle_after_done", {31'd0, busy}, 32'd0);
                ended = 1;
                break;
            end

            if (addr_valid) begin
                vcnt++;
                rdy = (hs > 0 || vcnt > stall_first) && (int'($urandom_range(99)) < ready_pct);
            end else begin
                rdy = 1'($urandom);
            end
            if (restart_mid && c == 3) begin
                start = 1'b1;
                req   = 16'($urandom);
            end
            addr_ready = rdy;

            if (addr_valid && rdy) begin
                hs++;
                if (exp_q.size() == 0) begin
                    chk("extra_handshake", {28'd0, addr}, 32'hFFFF_FFFF);
                end else begin
                    chk("order", {28'd0, addr}, exp_q.pop_front());
                end
                if (hs == abort_hs) begin
                    abort = 1'b1;
                    tick();
                    abort      = 1'b0;
                    start      = 1'b0;
                    addr_ready = 1'b0;
                    chk("abort_valid", {31'd0, addr_valid}, 32'd0);
                    chk("abort_busy", {31'd0, busy}, 32'd0);
                    chk("abort_no_done", {31'd0, done}, 32'd0);
                    ended = 1;
                    break;
                end
                mptr    = (int'(addr) + 1) % 16;
                last_hs = 1;
            end
            stalled = addr_valid && !rdy;
            held    = addr;
            tick();
            c++;
            start = 1'b0;
        end
        if (!ended) chk("sweep_timeout", 32'd0, 32'd1);
        addr_ready = 1'b0;
        tick();
    endtask

    initial begin
        bit ok;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        req        = '0;
        addr_ready = 1'b0;
        tick();
        tick();
        chk("rst_addr", {28'd0, addr}, 32'd0);
        chk("rst_valid", {31'd0, addr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // lines 0 and 15, then again after ptr wraps back to 0
        sweep(16'h8001, 100, 0, 0, 0);
        chk("ptr_wrapped", mptr, 0);
        sweep(16'h8001, 100, 0, 0, 0);
        // empty mask
        sweep(16'h0000, 100, 0, 0, 0);
        // abort on 3rd handshake (line 2), then resume from line 2
        sweep(16'hFFFF, 100, 0, 3, 0);
        chk("ptr_after_abort", mptr, 2);
        sweep(16'hFFFF, 100, 0, 0, 0);
        // stall first code for 5 cycles
        sweep(16'h00F0, 100, 5, 0, 0);
        // start while busy is ignored
        sweep(16'h0C30, 70, 0, 0, 1);

        // abort together with start in IDLE stays idle
        start = 1'b1;
        abort = 1'b1;
        req   = 16'hFFFF;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("still_idle", {31'd0, busy}, 32'd0);

        // reset mid-sweep while line 9 is presented
        start = 1'b1;
        req   = 16'h0200;
        tick();
        start = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (addr_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("mid_valid_seen", {31'd0, ok}, 32'd1);
        chk("mid_addr", {28'd0, addr}, 32'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_addr", {28'd0, addr}, 32'd0);
        chk("midrst_valid", {31'd0, addr_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        mptr = 0;
        tick();
        sweep(16'h0201, 100, 0, 0, 0);

        for (int n = 0; n < 8; n++) begin
            logic [15:0] r;
            int          ab;
            r  = 16'($urandom) & 16'($urandom);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
            sweep(r, int'($urandom_range(100, 30)), 0, ab, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
